// File: rtl/gf2m_trinomial_reducer.sv
// Sequential reduction of a (2M-1)-bit carry-less product modulo x^M + x^K + 1.
// Optional GF2M_RED_CNT_EN adds a 16-bit completed-transfer counter on red_count.
//
// state | meaning
// IDLE  | waiting for a product, in_ready=1
// FOLD  | folding acc; at most two cycles per operand since K < M/2
// DONE  | result presented on out_res until out_ready
module gf2m_trinomial_reducer #(
    parameter int  M  = 193,
    parameter int  K  = 15,
    localparam int CW = 2*M-1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_prod,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [M-1:0]  out_res,
`ifdef GF2M_RED_CNT_EN
    output logic [15:0]   red_count,
`endif
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, FOLD, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] acc_q, acc_d;
    logic [M-1:0]  res_q, res_d;
    logic          vld_q, vld_d;
    logic [1:0]    nfold_q, nfold_d;
    logic [CW-1:0] nxt;

    // x^M == x^K + 1, so the high part h folds back as h ^ (h << K).
    function automatic logic [CW-1:0] fold(input logic [CW-1:0] a);
        logic [CW-1:0] h;
        h = CW'(a[CW-1:M]);
        return CW'(a[M-1:0]) ^ h ^ (h << K);
    endfunction

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        res_d   = res_q;
        vld_d   = vld_q;
        nfold_d = nfold_q;
        nxt     = fold(acc_q);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d   = in_prod;
                    nfold_d = 2'd0;
                    state_d = FOLD;
                end
            end
            FOLD: begin
                nfold_d = nfold_q + 2'd1;
                if (nxt[CW-1:M] == '0) begin
                    res_d   = nxt[M-1:0];
                    vld_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    acc_d = nxt;
                end
            end
            DONE: begin
                if (out_ready) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            res_q   <= '0;
            vld_q   <= 1'b0;
            nfold_q <= 2'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            vld_q   <= vld_d;
            nfold_q <= nfold_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && state_q == FOLD)
            assert (nfold_q < 2'd2) else $fatal(1, "third fold cycle for one operand");
    end
`endif

`ifdef GF2M_RED_CNT_EN
    logic [15:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= 16'd0;
        else if (vld_q && out_ready)
            cnt_q <= cnt_q + 16'd1;
    end
    assign red_count = cnt_q;
`endif

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = vld_q;
    assign out_res   = res_q;

endmodule

// File: tb/tb_gf2m_trinomial_reducer.sv
// Directed and randomized checks of gf2m_trinomial_reducer against a long-division model.
module tb_gf2m_trinomial_reducer;
    localparam int M  = 193;
    localparam int K  = 15;
    localparam int CW = 2*M-1;
    localparam int N  = 10000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_prod = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [M-1:0]  out_res;
    logic          busy;
`ifdef GF2M_RED_CNT_EN
    logic [15:0]   red_count;
`endif

    int tests = 0;
    int fails = 0;

    gf2m_trinomial_reducer #(.M(M), .K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
`ifdef GF2M_RED_CNT_EN
        .red_count (red_count),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] xp(input int n);
        logic [CW-1:0] r;
        r = '0;
        r[n] = 1'b1;
        return r;
    endfunction

    // Reference: schoolbook long division by x^M + x^K + 1, top bit first.
    function automatic logic [M-1:0] ref_mod(input logic [CW-1:0] a);
        logic [CW-1:0] r;
        r = a;
        for (int i = CW-1; i >= M; i--) begin
            if (r[i]) begin
                r[i]       = 1'b0;
                r[i-M]     = ~r[i-M];
                r[i-M+K]   = ~r[i-M+K];
            end
        end
        return r[M-1:0];
    endfunction

    function automatic logic [CW-1:0] rand_prod();
        logic [415:0] t;
        for (int w = 0; w < 13; w++) t[w*32 +: 32] = $urandom();
        return t[CW-1:0] >> $urandom_range(200, 0);
    endfunction

    task automatic run_op(input string tag, input logic [CW-1:0] p,
                          input logic [M-1:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        check({tag, "_in_ready"}, M'(in_ready), M'(1));
        in_prod  = p;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 6) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, M'(lat), M'(exp_lat));
        check({tag, "_res"}, out_res, exp);
        check({tag, "_busy"}, M'(busy), M'(1));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_vld_drop"}, M'(out_valid), M'(0));
        check({tag, "_idle_ready"}, M'(in_ready), M'(1));
    endtask

    initial begin
        logic [M-1:0]  hold;
        logic [M-1:0]  expq[$];
        logic [CW-1:0] cur;
        int sent, got, cyc;

        #1;
        check("rst_out_valid", M'(out_valid), M'(0));
        check("rst_out_res", out_res, M'(0));
        check("rst_in_ready", M'(in_ready), M'(1));
        check("rst_busy", M'(busy), M'(0));
`ifdef GF2M_RED_CNT_EN
        check("rst_count", M'(red_count), M'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_stays", M'(busy), M'(0));

        run_op("x193", xp(193), M'(193'h8001), 1);
        run_op("x384", xp(384), (M'(1) << 191) | (M'(1) << 28) | (M'(1) << 13), 2);
        run_op("small", CW'(385'h1234), M'(193'h1234), 1);
        run_op("zero", '0, M'(0), 1);
        run_op("x370", xp(370), (M'(1) << 192) | (M'(1) << 177), 1);
        run_op("x371", xp(371), (M'(1) << 178) | (M'(1) << 15) | M'(1), 2);

        // Consumer stall with a competing input offered.
        @(negedge clk);
        in_prod  = xp(193);
        in_valid = 1'b1;
        @(negedge clk);
        in_prod = xp(384);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", M'(out_valid), M'(1));
            check("stall_res", out_res, M'(193'h8001));
            check("stall_in_ready", M'(in_ready), M'(0));
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_in_ready", M'(in_ready), M'(1));
        check("release_busy", M'(busy), M'(0));
        check("release_res_held", out_res, M'(193'h8001));
`ifdef GF2M_RED_CNT_EN
        check("count_directed", M'(red_count), M'(7));
`endif

        // Reset while folding.
        in_prod  = xp(384);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_fold_busy", M'(busy), M'(1));
        rst_n = 1'b0;
        #1;
        check("abort_valid", M'(out_valid), M'(0));
        check("abort_res", out_res, M'(0));
        check("abort_busy", M'(busy), M'(0));
`ifdef GF2M_RED_CNT_EN
        check("abort_count", M'(red_count), M'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", xp(193), M'(193'h8001), 1);

        // Random traffic with random valid/ready.
        sent = 0;
        got  = 0;
        cyc  = 0;
        cur  = rand_prod();
        while (got < N && cyc < 90000) begin
            @(negedge clk);
            cyc++;
            in_valid  = (sent < N) && ($urandom_range(3, 0) != 0);
            in_prod   = cur;
            out_ready = ($urandom_range(3, 0) != 0);
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("rand_unexpected", M'(1), M'(0));
                end else begin
                    hold = expq.pop_front();
                    check("rand_res", out_res, hold);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                expq.push_back(ref_mod(cur));
                sent++;
                cur = rand_prod();
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rand_got", M'(got), M'(N));
        check("rand_leftover", M'(expq.size()), M'(0));
`ifdef GF2M_RED_CNT_EN
        check("rand_count", M'(red_count), M'(N + 1));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
